// File: rtl/simon_pkg.sv
// Shared definitions for the Simon Says game blocks.
package simon_pkg;

    localparam int unsigned DEF_COLOUR_W = 2;
    localparam int unsigned DEF_MAX_LEN  = 16;

    localparam logic MODE_RECORD = 1'b0;
    localparam logic MODE_VERIFY = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/idle_timer.sv
// Inactivity counter; expired flags the cycle whose increment would reach the limit.
module idle_timer #(
    parameter int unsigned TO_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    input  logic [TO_W-1:0] limit,
    output logic            expired
);

    logic [TO_W-1:0] cnt;
    logic [TO_W-1:0] cnt_inc;

    assign cnt_inc = cnt + TO_W'(1);
    // A zero limit disables the timeout entirely.
    assign expired = (limit != '0) && (cnt_inc == limit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt_inc;
        end
    end

endmodule

// File: rtl/player_input_capture.sv
// Captures player colour presses in RECORD mode or checks them against a
// reference sequence in VERIFY mode, with an optional inactivity timeout.
module player_input_capture
    import simon_pkg::*;
#(
    parameter int unsigned COLOUR_W = DEF_COLOUR_W,
    parameter int unsigned MAX_LEN  = DEF_MAX_LEN,
    parameter int unsigned LEN_W    = $clog2(MAX_LEN + 1),
    parameter int unsigned TO_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         mode,
    input  logic                         colour_in,
    input  logic [COLOUR_W-1:0]          colour_val,
    input  logic [LEN_W-1:0]             sequence_len,
    input  logic [MAX_LEN*COLOUR_W-1:0]  expected_seq,
    input  logic [TO_W-1:0]              timeout_limit,
    output logic [MAX_LEN*COLOUR_W-1:0]  sequence_val,
    output logic [LEN_W-1:0]             count,
    output logic                         busy,
    output logic                         done,
    output logic                         match,
    output logic                         mismatch,
    output logic                         timeout
);

    state_t              state;
    logic                mode_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    count_inc;
    logic [COLOUR_W-1:0] exp_slot;
    logic                tmr_clr;
    logic                tmr_inc;
    logic                tmr_expired;

    assign count_inc = count + LEN_W'(1);

    // Reference entry for the slot about to be written.
    always_comb begin
        exp_slot = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (count == LEN_W'(i)) begin
                exp_slot = expected_seq[i*COLOUR_W +: COLOUR_W];
            end
        end
    end

    assign tmr_clr = en && ((state == ST_IDLE) || ((state == ST_COLLECT) && colour_in));
    assign tmr_inc = en && (state == ST_COLLECT) && !colour_in && (len_q != '0);

    idle_timer #(
        .TO_W (TO_W)
    ) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .inc     (tmr_inc),
        .limit   (timeout_limit),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            mode_q       <= MODE_RECORD;
            len_q        <= '0;
            sequence_val <= '0;
            count        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            match        <= 1'b0;
            mismatch     <= 1'b0;
            timeout      <= 1'b0;
        end else if (!en) begin
            // sequence_val and count stay readable after the controller drops en.
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            match    <= 1'b0;
            mismatch <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state        <= ST_COLLECT;
                    mode_q       <= mode;
                    len_q        <= (sequence_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : sequence_len;
                    sequence_val <= '0;
                    count        <= '0;
                    busy         <= 1'b1;
                    done         <= 1'b0;
                    match        <= 1'b0;
                    mismatch     <= 1'b0;
                    timeout      <= 1'b0;
                end
                ST_COLLECT: begin
                    if (len_q == '0) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        match <= 1'b1;
                    end else if (colour_in) begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (count == LEN_W'(i)) begin
                                sequence_val[i*COLOUR_W +: COLOUR_W] <= colour_val;
                            end
                        end
                        count <= count_inc;
                        if ((mode_q == MODE_VERIFY) && (colour_val != exp_slot)) begin
                            state    <= ST_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            mismatch <= 1'b1;
                        end else if (count_inc == len_q) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            match <= 1'b1;
                        end
                    end else if (tmr_expired) begin
                        state   <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_input_capture.sv
// Directed bench for player_input_capture; terminal results go through a scoreboard queue.
module tb_player_input_capture;

    localparam int unsigned COLOUR_W = 2;
    localparam int unsigned MAX_LEN  = 16;
    localparam int unsigned LEN_W    = 5;
    localparam int unsigned TO_W     = 16;
    localparam int unsigned SEQ_W    = MAX_LEN * COLOUR_W;

    typedef struct packed {
        logic             m;
        logic             mm;
        logic             to;
        logic [LEN_W-1:0] cnt;
        logic [SEQ_W-1:0] seq;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic                mode;
    logic                colour_in;
    logic [COLOUR_W-1:0] colour_val;
    logic [LEN_W-1:0]    sequence_len;
    logic [SEQ_W-1:0]    expected_seq;
    logic [TO_W-1:0]     timeout_limit;
    logic [SEQ_W-1:0]    sequence_val;
    logic [LEN_W-1:0]    count;
    logic                busy;
    logic                done;
    logic                match;
    logic                mismatch;
    logic                timeout;

    int   tests = 0;
    int   fails = 0;
    exp_t sb_q[$];
    logic done_prev = 1'b0;

    always #5 clk = ~clk;

    player_input_capture #(
        .COLOUR_W (COLOUR_W),
        .MAX_LEN  (MAX_LEN),
        .LEN_W    (LEN_W),
        .TO_W     (TO_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .mode          (mode),
        .colour_in     (colour_in),
        .colour_val    (colour_val),
        .sequence_len  (sequence_len),
        .expected_seq  (expected_seq),
        .timeout_limit (timeout_limit),
        .sequence_val  (sequence_val),
        .count         (count),
        .busy          (busy),
        .done          (done),
        .match         (match),
        .mismatch      (mismatch),
        .timeout       (timeout)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: each rising done pops one expectation.
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected_done: got done=1, expected no completion");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_flags", 64'({match, mismatch, timeout}), 64'({e.m, e.mm, e.to}));
                check("sb_count", 64'(count), 64'(e.cnt));
                check("sb_seq", 64'(sequence_val), 64'(e.seq));
            end
        end
        done_prev <= done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [COLOUR_W-1:0] c);
        colour_in  = 1'b1;
        colour_val = c;
        tick();
        colour_in  = 1'b0;
    endtask

    task automatic start(input logic m, input logic [LEN_W-1:0] len,
                         input logic [SEQ_W-1:0] exp_seq, input logic [TO_W-1:0] lim);
        mode          = m;
        sequence_len  = len;
        expected_seq  = exp_seq;
        timeout_limit = lim;
        en            = 1'b1;
        tick();
    endtask

    task automatic stop();
        en = 1'b0;
        tick();
    endtask

    task automatic push(input logic m, input logic mm, input logic to,
                        input logic [LEN_W-1:0] c, input logic [SEQ_W-1:0] s);
        exp_t e;
        e.m = m; e.mm = mm; e.to = to; e.cnt = c; e.seq = s;
        sb_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [SEQ_W-1:0] model;
        logic             ok;

        rst = 1'b0; en = 1'b0; mode = 1'b0; colour_in = 1'b0; colour_val = '0;
        sequence_len = '0; expected_seq = '0; timeout_limit = '0;
        tick(); tick();
        check("reset_outputs", 64'({sequence_val, count, busy, done, match, mismatch, timeout}), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        tick();

        // RECORD, 14 entries cycling 0..3
        model = '0;
        for (int i = 0; i < 14; i++) model[i*COLOUR_W +: COLOUR_W] = COLOUR_W'(i % 4);
        push(1'b1, 1'b0, 1'b0, LEN_W'(14), model);
        start(1'b0, LEN_W'(14), '0, '0);
        check("t1_busy", 64'({busy, done}), 64'(2'b10));
        press(2'd0);
        check("t1_first_press", 64'({count, sequence_val[1:0]}), 64'({5'd1, 2'd0}));
        for (int i = 1; i < 13; i++) press(COLOUR_W'(i % 4));
        check("t1_not_done_13", 64'(done), 64'(0));
        press(2'd1);
        check("t1_done_latency", 64'({done, match, busy}), 64'(3'b110));
        stop();

        // VERIFY, mismatch on third entry
        push(1'b0, 1'b1, 1'b0, LEN_W'(3), SEQ_W'(32'h0B));
        start(1'b1, LEN_W'(4), SEQ_W'(32'h1B), '0);
        press(2'd3); press(2'd2); press(2'd0);
        check("t2_mismatch_latency", 64'({done, mismatch}), 64'(2'b11));
        stop();

        // VERIFY full match, then DONE ignores presses and en drop holds data
        push(1'b1, 1'b0, 1'b0, LEN_W'(4), SEQ_W'(32'hA5));
        start(1'b1, LEN_W'(4), SEQ_W'(32'hA5), '0);
        press(2'd1); press(2'd1); press(2'd2); press(2'd2);
        press(2'd3);
        check("t3_done_ignores_press", 64'({done, match, count, sequence_val}), 64'({2'b11, 5'd4, 32'hA5}));
        stop();
        check("t3_en_drop_flags", 64'({busy, done, match, mismatch, timeout}), 64'(0));
        check("t3_en_drop_held", 64'({count, sequence_val}), 64'({5'd4, 32'hA5}));

        // VERIFY mismatch on the final entry
        push(1'b0, 1'b1, 1'b0, LEN_W'(2), SEQ_W'(32'h0D));
        start(1'b1, LEN_W'(2), SEQ_W'(32'h09), '0);
        press(2'd1); press(2'd3);
        stop();

        // Timeout of 5 after one press
        push(1'b0, 1'b0, 1'b1, LEN_W'(1), SEQ_W'(32'h2));
        start(1'b0, LEN_W'(4), '0, TO_W'(5));
        press(2'd2);
        repeat (4) tick();
        check("t4_before_timeout", 64'({done, busy}), 64'(2'b01));
        tick();
        check("t4_timeout_edge", 64'({done, timeout}), 64'(2'b11));
        stop();

        // Strobe coincident with expiry wins and restarts the timer
        push(1'b0, 1'b0, 1'b1, LEN_W'(1), SEQ_W'(32'h3));
        start(1'b0, LEN_W'(4), '0, TO_W'(3));
        tick(); tick();
        press(2'd3);
        check("t5_strobe_wins", 64'({done, busy, count}), 64'({2'b01, 5'd1}));
        tick(); tick();
        check("t5_timer_restarted", 64'(done), 64'(0));
        tick();
        check("t5_timeout_after_press", 64'({done, timeout}), 64'(2'b11));
        stop();

        // Timeout disabled
        start(1'b0, LEN_W'(4), '0, '0);
        ok = 1'b1;
        repeat (1000) begin
            tick();
            if (!busy || done) ok = 1'b0;
        end
        check("t6_no_timeout", 64'(ok), 64'(1));
        stop();

        // Length 20 clamps to 16
        model = '0;
        for (int i = 0; i < 16; i++) model[i*COLOUR_W +: COLOUR_W] = COLOUR_W'((i + 1) % 4);
        push(1'b1, 1'b0, 1'b0, LEN_W'(16), model);
        start(1'b0, LEN_W'(20), '0, '0);
        for (int i = 0; i < 15; i++) press(COLOUR_W'((i + 1) % 4));
        check("t7_not_done_15", 64'(done), 64'(0));
        press(2'd0);
        check("t7_clamped_done", 64'({done, match}), 64'(2'b11));
        stop();

        // Length 0 completes one cycle after entry
        push(1'b1, 1'b0, 1'b0, LEN_W'(0), '0);
        start(1'b0, LEN_W'(0), '0, '0);
        check("t8_entry", 64'({busy, done}), 64'(2'b10));
        tick();
        check("t8_zero_len_done", 64'({done, match}), 64'(2'b11));
        stop();

        // Asynchronous reset mid-COLLECT
        start(1'b0, LEN_W'(8), '0, '0);
        press(2'd1); press(2'd2); press(2'd3);
        check("t9_pre_reset", 64'({busy, count}), 64'({1'b1, 5'd3}));
        #2;
        rst = 1'b0;
        #1;
        check("t9_async_reset", 64'({sequence_val, count, busy, done, match, mismatch, timeout}), 64'(0));
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("t9_idle_after_reset", 64'({busy, done}), 64'(0));

        tick();
        check("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
